aes_key_schedule: RTL
=====================

# aes_key_schedule

Parametrised, word-serial AES key expansion engine supporting 128/192/256-bit keys. It accepts a cipher key over a valid/ready handshake and streams the Nr+1 128-bit round keys in order over a second valid/ready handshake. Output backpressure is honoured. It sits between key storage and the AES-CTR round datapath, and is the generalised successor to the fixed AES-256 expansion FSM.

## Interface
- KEY_BITS, 256, key size; legal values 128, 192 and 256. Derived: Nk = KEY_BITS/32; Nr = Nk+6; NW = 4·(Nr+1), which is 44/52/60 words.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- key_in  in  256  cipher key, MSB-aligned: key_in[255:224] = w[0]. For KEY_BITS<256 the unused low bits are ignored.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  high only in IDLE.
- rk_data  out  128  round key; rk_data[127:96] = w[4k], rk_data[31:0] = w[4k+3].
- rk_idx  out  4  round index k, 0..Nr.
- rk_valid  out  1  rk_data, rk_idx and rk_last are valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_last  out  1  high with rk_idx == Nr.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- **IDLE**
  - key_ready = 1.
  - On key_valid && key_ready: register the key, set i = 0, set rcon = 8'h01, then go to STREAM.
- **STREAM**
  - Produces word w[i] in any cycle not stalled.
  - For i < Nk: w[i] = key word i.
  - For i ≥ Nk: w[i] = win[oldest] ^ f(w[i-1]), where:
    - if i mod Nk == 0: f = SubWord(RotWord(w)) ^ {rcon, 24'h0}, and rcon advances by xtime (8'h80 → 8'h1b).
    - else if Nk == 8 and i mod 8 == 4: f = SubWord(w).
    - otherwise: f = identity.
  - The window is a shift register of Nk words (max 8), always holding w[i-Nk..i-1]. Each produced word is shifted in.
  - Each produced word also enters a 3-word assembler. The 4th word of a group transfers {asm0, asm1, asm2, w} into the output register, sets rk_valid, and sets rk_idx = i/4.
  - Stall: if the 4th word is due, rk_valid = 1 and rk_ready = 0, then no word is produced. i, the window, rcon and the assembler all hold.
  - After w[NW-1] is transferred, go to DRAIN.
- **DRAIN**
  - Wait for the final rk_valid && rk_ready, then go to IDLE.
- Output register rules:
  - rk_valid clears on acceptance unless a new key is loaded in the same cycle.
  - Data is stable while rk_valid && !rk_ready.
- key_valid is ignored outside IDLE.
- SubWord is combinational (4 S-box lookups); there are no multi-cycle byte loops.

## Timing
- Reset values: key_ready = 1 (IDLE), rk_valid = 0, rk_last = 0, busy = 0, rk_idx = 0, rk_data = 0. Internal i, rcon, window and assembler are cleared.
- Key handshake at edge E0. w[0..3] are produced on edges E1..E4. rk_valid is high after E4 with rk_idx = 0.
- With rk_ready held at 1, one round key is delivered every 4 cycles. rk_last is asserted after edge E(NW), i.e. E44, E52 or E60.
- Acceptance of the last key at edge Ef: key_ready = 1 and busy = 0 after Ef. The earliest next key handshake is at Ef+1.
- Transfer and acceptance at the same edge: the old key is consumed and the new key is loaded. rk_valid stays 1.
- Reset asserted mid-stream: all outputs return to their reset values immediately (asynchronous). There is no partial round-key output after reset deassertion.

## Structure
- Package aes_pkg holds:
  - the S-box constant/function;
  - the xtime function;
  - the localparams Nk, Nr, NW derived from KEY_BITS;
  - the FSM state enum;
  - the word type (32 bits).
- Sub-module aes_subword: 32-bit combinational SubWord built from 4 S-box lookups, instantiated once. Both RotWord+SubWord and the plain SubWord share it through an input mux.
- Elaboration check: KEY_BITS not in {128, 192, 256} is a fatal error.

## Test plan
- KEY_BITS=128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready = 1:
  - rk_idx 0 equals the key.
  - rk_idx 1 begins a0fafe17.
  - rk_idx 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, with rk_last = 1, 11 keys in 44 cycles.
- KEY_BITS=192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - rk_idx 12 = e98ba06f 448c773c 8ecc7204 01002202.
- KEY_BITS=256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - rk_idx 2 begins 9ba35411.
  - rk_idx 14 = fe4890d1 e6188d0b 046df344 706c631e.
- Random rk_ready backpressure (30% low):
  - rk_data/rk_idx stable while stalled.
  - Same 15 keys as the unstalled run; no drops or duplicates.
- key_valid pulsed while busy: ignored and key_ready stays 0. Then rst low at rk_idx 5 for 1 cycle:
  - outputs go to reset values immediately;
  - a fresh key yields correct rk_idx 0 at E4.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared types and helpers for the AES key expansion engine:
//     word_t     - 32-bit key-schedule word
//     state_t    - key schedule FSM states (IDLE, STREAM, DRAIN)
//     SBOX/sbox  - AES forward S-box table and lookup
//     xtime      - multiply-by-x in GF(2^8), used to advance rcon
//     key_nk/nr/nw - Nk, Nr and NW derived from the key size in bits
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    // Largest key (256 bits) is 8 words; the window is sized for it.
    localparam int MAX_NK = 8;

    // Index 0 is the leftmost entry, so SBOX[b] is the S-box output for byte b.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int key_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int key_nr(input int key_bits);
        return key_nk(key_bits) + 6;
    endfunction

    function automatic int key_nw(input int key_bits);
        return 4 * (key_nr(key_bits) + 1);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ----------------------------------------------------------------------------
// aes_subword
//   Combinational SubWord: applies the AES S-box to each byte of a word.
//   Ports:
//     src - input word
//     sub - word with every byte substituted
// ----------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] src,
    output logic [31:0] sub
);

    assign sub[31:24] = sbox(src[31:24]);
    assign sub[23:16] = sbox(src[23:16]);
    assign sub[15:8]  = sbox(src[15:8]);
    assign sub[7:0]   = sbox(src[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// ----------------------------------------------------------------------------
// aes_key_schedule
//   Word-serial AES key expansion for 128/192/256-bit keys. Accepts a cipher
//   key on a valid/ready handshake, produces one expanded word per cycle and
//   streams the Nr+1 round keys in order, honouring output backpressure.
//   Ports:
//     clk, rst         - clock, asynchronous active-low reset
//     key_in[255:0]    - cipher key, MSB-aligned (key_in[255:224] = w[0])
//     key_valid/ready  - key handshake; key_ready is high only in IDLE
//     rk_data[127:0]   - round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}
//     rk_idx[3:0]      - round index k
//     rk_valid/ready   - round key handshake
//     rk_last          - marks round key Nr
//     busy             - high whenever not IDLE
// ----------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    localparam int         NK     = key_nk(KEY_BITS);
    localparam int         NW     = key_nw(KEY_BITS);
    localparam int         OLDEST = MAX_NK - NK;   // window slot holding w[i-Nk]
    localparam logic [5:0] NK_I   = 6'(NK);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [5:0] LAST_I = 6'(NW - 1);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $fatal(1, "aes_key_schedule: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    state_t     state, state_next;
    word_t      key_w [MAX_NK];
    word_t      win   [MAX_NK];  // win[MAX_NK-1] is the newest word w[i-1]
    word_t      asm_w [3];
    logic [5:0] i;
    logic [2:0] pos;             // i mod Nk, kept as a counter to avoid a divider
    logic [7:0] rcon;

    word_t prev, oldest, sub_src, sub_out, w_new;
    logic  group_end, stall, produce, load;

    assign prev      = win[MAX_NK-1];
    assign oldest    = win[OLDEST];
    assign group_end = (i[1:0] == 2'd3);
    // The 4th word of a group cannot be produced while the previous round
    // key is still waiting in the output register.
    assign stall     = group_end && rk_valid && !rk_ready;

    // One S-box bank serves both RotWord+SubWord and plain SubWord.
    assign sub_src = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .src (sub_src),
        .sub (sub_out)
    );

    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case leaves a variable unassigned (a latch).
    always_comb begin
        w_new = oldest ^ prev;
        if (i < NK_I) begin
            w_new = key_w[i[2:0]];
        end else if (pos == 3'd0) begin
            w_new = oldest ^ sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && pos == 3'd4) begin
            w_new = oldest ^ sub_out;
        end
    end

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        busy       = 1'b1;
        load       = 1'b0;
        produce    = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                busy      = 1'b0;
                if (key_valid) begin
                    load       = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                produce = !stall;
                if (produce && i == LAST_I) state_next = DRAIN;
            end
            DRAIN: begin
                if (rk_valid && rk_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the key store, window and assembler are small register
            // arrays, so they are cleared with everything else; nothing stale
            // from an interrupted key can reach a later output.
            for (int j = 0; j < MAX_NK; j++) begin
                key_w[j] <= '0;
                win[j]   <= '0;
            end
            for (int j = 0; j < 3; j++) asm_w[j] <= '0;
            i        <= '0;
            pos      <= '0;
            rcon     <= '0;
            rk_data  <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
        end else begin
            if (load) begin
                for (int j = 0; j < MAX_NK; j++) key_w[j] <= key_in[255 - 32*j -: 32];
                i    <= '0;
                pos  <= '0;
                rcon <= 8'h01;
            end

            if (produce) begin
                i   <= i + 6'd1;
                pos <= (pos == NK_M1) ? 3'd0 : pos + 3'd1;
                for (int j = 0; j < MAX_NK - 1; j++) win[j] <= win[j+1];
                win[MAX_NK-1] <= w_new;
                if (i >= NK_I && pos == 3'd0) rcon <= xtime(rcon);
                case (i[1:0])
                    2'd0:    asm_w[0] <= w_new;
                    2'd1:    asm_w[1] <= w_new;
                    2'd2:    asm_w[2] <= w_new;
                    default: ;
                endcase
            end

            // A new transfer takes priority over clearing on acceptance, so
            // back-to-back round keys keep rk_valid high.
            if (produce && group_end) begin
                rk_data  <= {asm_w[0], asm_w[1], asm_w[2], w_new};
                rk_idx   <= i[5:2];
                rk_valid <= 1'b1;
                rk_last  <= (i == LAST_I);
            end else if (rk_valid && rk_ready) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end
        end
    end

endmodule
